// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand frame loader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package operand_loader_pkg;

   localparam int WORD_W      = 16;
   localparam int FRAME_PAIRS = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_DATA = 2'd1,
      LOAD_WGT  = 2'd2,
      PRESENT   = 2'd3
   } state_t;

   // Word-index counter width; a single-pair frame still needs a one-bit counter.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/operand_frame_loader_if.sv
// Word-stream input and frame output bundle of the operand frame loader.
// Latency: none (wiring only).
// Backpressure: in_ready throttles the word stream, out_ready holds the presented frame.
interface operand_frame_loader_if
   import operand_loader_pkg::*;
#(
   parameter int N = FRAME_PAIRS,
   parameter int W = WORD_W
) ();

   logic           in_valid;
   logic           in_ready;
   logic           in_sof;
   logic [W-1:0]   in_data;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] out_data;
   logic [N*W-1:0] out_weights;
   logic           frame_err;

   // Word producer / frame consumer side.
   modport master (
      output in_valid, in_sof, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_weights, frame_err
   );

   // Loader side.
   modport slave (
      input  in_valid, in_sof, in_data, out_ready,
      output in_ready, out_valid, out_data, out_weights, frame_err
   );

endinterface

// File: rtl/frame_word_counter.sv
// Word index within a load phase: clear, increment, wrap at N-1, terminal-count flag.
// Latency: count updates on the clock edge after clr/inc; tc is combinational from the count.
// Backpressure: none; the owner only pulses inc on accepted words.
module frame_word_counter
   import operand_loader_pkg::*;
#(
   parameter int N = FRAME_PAIRS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                inc,
   output logic [cnt_w(N)-1:0] cnt,
   output logic                tc
);

   localparam int CW = cnt_w(N);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear applies first so clr+inc together loads the value 1 (restart with word 0 stored).
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end
      if (inc) begin
         if (cnt_d == CW'(N - 1)) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_d + CW'(1);
         end
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/operand_frame_loader.sv
// Assembles a serial word stream into N data + N weight words and presents them as one frame.
// Latency: out_valid rises the cycle after the last word of a frame is accepted.
// Backpressure: in_ready drops while a frame is presented; the frame is held until out_ready.
// Optional feature macro: OPERAND_LOADER_WEIGHT_KEEP_EN (sof header word, MSB=1 keeps old weights).
module operand_frame_loader
   import operand_loader_pkg::*;
#(
   parameter int N = FRAME_PAIRS,
   parameter int W = WORD_W
) (
   input  logic                  clk,
   input  logic                  rst,
   operand_frame_loader_if.slave bus
);

   localparam int CW = cnt_w(N);

   state_t         state_q, state_d;
   logic [N*W-1:0] data_q, data_d;
   logic [N*W-1:0] wgt_q, wgt_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           err_q, err_d;
   logic           keep_q, keep_d;

   logic           cnt_clr;
   logic           cnt_inc;
   logic           cnt_tc;
   logic [CW-1:0]  cnt;

   logic           word_acc;
   logic           frame_acc;
   logic           start_frame;

   assign word_acc    = bus.in_valid && in_ready_q;
   assign frame_acc   = out_valid_q && bus.out_ready;
   // in_ready is low in PRESENT, so any accepted sof word opens a new frame.
   assign start_frame = word_acc && bus.in_sof;

   frame_word_counter #(.N(N)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (cnt),
      .tc  (cnt_tc)
   );

   // Next-state, storage writes and registered handshake outputs.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      wgt_d   = wgt_q;
      err_d   = err_q;
      keep_d  = keep_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Non-sof words are dropped here; sof handling is below.
         end
         LOAD_DATA: begin
            if (word_acc && !bus.in_sof) begin
               data_d[int'(cnt) * W +: W] = bus.in_data;
               cnt_inc = 1'b1;
               if (cnt_tc) begin
                  state_d = keep_q ? PRESENT : LOAD_WGT;
               end
            end
         end
         LOAD_WGT: begin
            if (word_acc && !bus.in_sof) begin
               wgt_d[int'(cnt) * W +: W] = bus.in_data;
               cnt_inc = 1'b1;
               if (cnt_tc) begin
                  state_d = PRESENT;
               end
            end
         end
         PRESENT: begin
            if (frame_acc) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A sof word always restarts framing; arriving mid-frame it flags the lost partial frame.
      if (start_frame) begin
         if (state_q != IDLE) begin
            err_d = 1'b1;
         end
         cnt_clr = 1'b1;
`ifdef OPERAND_LOADER_WEIGHT_KEEP_EN
         // Header word: only its MSB is used, the payload follows.
         keep_d  = bus.in_data[W-1];
         state_d = LOAD_DATA;
`else
         keep_d             = 1'b0;
         data_d[W-1:0]      = bus.in_data;
         if (N > 1) begin
            cnt_inc = 1'b1;
            state_d = LOAD_DATA;
         end else begin
            state_d = LOAD_WGT;
         end
`endif
      end

      in_ready_d  = (state_d != PRESENT);
      out_valid_d = (state_d == PRESENT);
   end

   // FSM state, frame storage and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         wgt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         keep_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         wgt_q       <= wgt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         keep_q      <= keep_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = data_q;
   assign bus.out_weights = wgt_q;
   assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_operand_frame_loader.sv
// Bench for operand_frame_loader: queue-based frame model checked every cycle, directed cases, random traffic.
// Latency: n/a.
// Backpressure: exercised by holding and randomizing out_ready.
module tb_operand_frame_loader;
   import operand_loader_pkg::*;

   localparam int N = FRAME_PAIRS;
   localparam int W = WORD_W;
`ifdef OPERAND_LOADER_WEIGHT_KEEP_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic clk;
   logic rst_n;

   operand_frame_loader_if #(.N(N), .W(W)) bus ();

   operand_frame_loader #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_data[N];
   logic [W-1:0] m_wgt[N];
   bit m_coll, m_pres, m_err, m_rdy, m_keep;

   function automatic logic [N*W-1:0] pack(input logic [W-1:0] a[N]);
      logic [N*W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*W +: W] = a[i];
      return v;
   endfunction

   task automatic model_step();
      bit acc;
      if (!rst_n) begin
         m_q.delete();
         m_coll = 0; m_pres = 0; m_err = 0; m_rdy = 0; m_keep = 0;
         for (int i = 0; i < N; i++) begin
            m_data[i] = '0;
            m_wgt[i]  = '0;
         end
         return;
      end
      acc = bus.in_valid && m_rdy;
      if (m_pres) begin
         if (bus.out_ready) m_pres = 0;
      end else if (acc) begin
         if (bus.in_sof) begin
            if (m_coll) m_err = 1;
            m_coll = 1;
            m_q.delete();
            if (HDR) begin
               m_keep = bus.in_data[W-1];
            end else begin
               m_keep = 0;
               m_q.push_back(bus.in_data);
            end
         end else if (m_coll) begin
            m_q.push_back(bus.in_data);
         end
         if (m_coll && m_q.size() == (m_keep ? N : 2 * N)) begin
            for (int i = 0; i < N; i++) m_data[i] = m_q[i];
            if (!m_keep) for (int i = 0; i < N; i++) m_wgt[i] = m_q[N + i];
            m_coll = 0;
            m_pres = 1;
         end
      end
      m_rdy = !m_pres;
   endtask

   initial begin
      model_step();
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("in_ready", bus.in_ready, m_rdy);
         chk("out_valid", bus.out_valid, m_pres);
         chk("frame_err", bus.frame_err, m_err);
         if (m_pres) begin
            chk("out_data", bus.out_data, pack(m_data));
            chk("out_weights", bus.out_weights, pack(m_wgt));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   logic [W-1:0] basic[8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd12, 16'd6, 16'd4, 16'd3};
   logic [W-1:0] seq[$];

   // Called at a negedge; returns at the negedge after the word is taken, with in_valid low.
   task automatic send_word(input logic sof, input logic [W-1:0] d);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      bus.in_data  = d;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("accept_timeout", (t < 50), 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   // Sends seq as a frame body, with a plain header word first when headers are in use.
   task automatic send_seq();
      if (HDR) send_word(1'b1, 16'h0000);
      for (int i = 0; i < seq.size(); i++) send_word((i == 0) && !HDR, seq[i]);
   endtask

   task automatic send_basic();
      seq.delete();
      for (int i = 0; i < 8; i++) seq.push_back(basic[i]);
      send_seq();
   endtask

   task automatic check_basic(input string tag);
      int sum;
      chk({tag, "_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_data"}, bus.out_data, 64'h0004_0003_0002_0001);
      chk({tag, "_wgt"}, bus.out_weights, 64'h0003_0004_0006_000C);
      sum = 0;
      for (int i = 0; i < N; i++) sum += int'(bus.out_data[i*W +: W]) * int'(bus.out_weights[i*W +: W]);
      chk({tag, "_sum"}, sum, 48);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_out_data", bus.out_data, 64'h0);
      chk("rst_out_wgt", bus.out_weights, 64'h0);
      chk("rst_err", bus.frame_err, 1'b0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Basic frame with the consumer always ready.
      bus.out_ready = 1'b1;
      send_basic();
      check_basic("basic");
      @(negedge clk);
      chk("basic_consumed", bus.out_valid, 1'b0);

      // Backpressure: frame held, input stalled even with a sof word offered.
      bus.out_ready = 1'b0;
      send_basic();
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b1;
      bus.in_data  = 16'hDEAD;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 1'b0);
         chk("bp_data", bus.out_data, 64'h0004_0003_0002_0001);
      end
      check_basic("bp");
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_valid", bus.out_valid, 1'b0);
      chk("bp_release_ready", bus.in_ready, 1'b1);

      // Mid-frame resync.
      seq.delete();
      seq.push_back(16'd5); seq.push_back(16'd6); seq.push_back(16'd7);
      send_seq();
      chk("resync_no_err_yet", bus.frame_err, 1'b0);
      send_basic();
      chk("resync_err", bus.frame_err, 1'b1);
      check_basic("resync");
      @(negedge clk);

      // Stray words in IDLE are dropped.
      send_word(1'b0, 16'd9);
      send_word(1'b0, 16'd9);
      chk("stray_valid", bus.out_valid, 1'b0);
      send_basic();
      check_basic("stray");
      @(negedge clk);

      // Asynchronous reset while loading weights.
      bus.out_ready = 1'b0;
      if (HDR) send_word(1'b1, 16'h0000);
      for (int i = 0; i < 6; i++) send_word((i == 0) && !HDR, 16'(i + 20));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", bus.out_data, 64'h0);
      chk("arst_wgt", bus.out_weights, 64'h0);
      chk("arst_err", bus.frame_err, 1'b0);
      chk("arst_ready", bus.in_ready, 1'b0);
      chk("arst_valid", bus.out_valid, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      send_word(1'b0, 16'd4);
      send_word(1'b0, 16'd3);
      repeat (3) @(negedge clk);
      chk("arst_no_frame", bus.out_valid, 1'b0);
      bus.out_ready = 1'b1;
      send_basic();
      check_basic("arst_new");
      @(negedge clk);

`ifdef OPERAND_LOADER_WEIGHT_KEEP_EN
      // Keep flag: data only, previous weights reused.
      send_word(1'b1, 16'h8000);
      for (int i = 0; i < N; i++) send_word(1'b0, 16'(i + 5));
      chk("keep_valid", bus.out_valid, 1'b1);
      chk("keep_data", bus.out_data, 64'h0008_0007_0006_0005);
      chk("keep_wgt", bus.out_weights, 64'h0003_0004_0006_000C);
      @(negedge clk);
`endif

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_sof    = ($urandom_range(0, 9) == 0);
         bus.in_data   = 16'($urandom);
         bus.out_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
